voice_mixer: RTL and testbench

Time-multiplexed voice summer for the audio path. Once per audio frame it accepts NUM_VOICES signed voice samples, each with an unsigned gain, over a valid/ready stream. It multiplies each sample by its gain, accumulates the products at full precision, and emits one wide signed mix word. That word feeds the saturating clipper stage, which shifts right by GAIN_WIDTH and narrows back to SAMPLE_WIDTH.

---
 rtl/voice_mixer_pkg.sv | 18 +
 rtl/voice_mixer_if.sv | 30 +++
 rtl/voice_mac.sv | 44 ++++
 rtl/voice_mixer.sv | 113 +++++++++++
 tb/tb_voice_mixer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/voice_mixer_pkg.sv
// Shared audio-path types and width helpers for the voice mixer and the clipper that follows it.
package voice_mixer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StFlush,
    StDone
  } mixer_state_t;

  // Mix word width that can hold num_voices worst-case products without overflow.
  function automatic int unsigned mix_width(input int unsigned num_voices,
                                            input int unsigned sample_width,
                                            input int unsigned gain_width);
    return sample_width + gain_width + $clog2(num_voices);
  endfunction

endpackage

// File: rtl/voice_mixer_if.sv
// Voice beat stream plus mix result bundle between the voice source and the mixer.
interface voice_mixer_if
  import voice_mixer_pkg::*;
#(
  parameter int unsigned NUM_VOICES   = 8,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned GAIN_WIDTH   = 8,
  parameter int unsigned WIDTH_FULL   = mix_width(NUM_VOICES, SAMPLE_WIDTH, GAIN_WIDTH)
);

  logic                         sample_tick_in;
  logic [SAMPLE_WIDTH-1:0]      voice_sample_in;
  logic [GAIN_WIDTH-1:0]        voice_gain_in;
  logic                         voice_valid_in;
  logic                         voice_ready_out;
  logic signed [WIDTH_FULL-1:0] mix_out;
  logic                         mix_valid_out;
  logic                         overrun_out;

  modport master (
    output sample_tick_in, voice_sample_in, voice_gain_in, voice_valid_in,
    input  voice_ready_out, mix_out, mix_valid_out, overrun_out
  );

  modport slave (
    input  sample_tick_in, voice_sample_in, voice_gain_in, voice_valid_in,
    output voice_ready_out, mix_out, mix_valid_out, overrun_out
  );

endinterface

// File: rtl/voice_mac.sv
// Two-stage multiply-accumulate: registered sample x gain product, then sign-extended accumulate.
module voice_mac #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned GAIN_WIDTH   = 8,
  parameter int unsigned WIDTH_FULL   = 27
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         clear_in,
  input  logic                         en_in,
  input  logic [SAMPLE_WIDTH-1:0]      sample_in,
  input  logic [GAIN_WIDTH-1:0]        gain_in,
  output logic signed [WIDTH_FULL-1:0] acc_out
);

  localparam int unsigned ProdW = SAMPLE_WIDTH + GAIN_WIDTH + 1;

  logic signed [ProdW-1:0]      prod_d, prod_q;
  logic                         prod_vld_q;
  logic signed [WIDTH_FULL-1:0] acc_q;

  // Gain is unsigned, so it is zero-extended before the signed multiply.
  assign prod_d = $signed({{(GAIN_WIDTH + 1){sample_in[SAMPLE_WIDTH-1]}}, sample_in}) *
                  $signed({{(SAMPLE_WIDTH + 1){1'b0}}, gain_in});

  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      if (en_in) begin
        prod_q <= prod_d;
      end
      prod_vld_q <= en_in;
      if (prod_vld_q) begin
        acc_q <= acc_q + {{(WIDTH_FULL - ProdW){prod_q[ProdW-1]}}, prod_q};
      end
    end
  end

  assign acc_out = acc_q;

endmodule

// File: rtl/voice_mixer.sv
// Frame-sequenced voice summer: collects NUM_VOICES sample/gain beats per tick, emits exact mix.
module voice_mixer
  import voice_mixer_pkg::*;
#(
  parameter int unsigned NUM_VOICES   = 8,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned GAIN_WIDTH   = 8,
  parameter int unsigned WIDTH_FULL   = mix_width(NUM_VOICES, SAMPLE_WIDTH, GAIN_WIDTH)
) (
  input logic          clk_in,
  input logic          rst_in,
  voice_mixer_if.slave bus
);

  localparam int unsigned    CntW     = $clog2(NUM_VOICES);
  localparam logic [CntW-1:0] LastBeat = CntW'(NUM_VOICES - 1);

  mixer_state_t                 state_d, state_q;
  logic [CntW-1:0]              cnt_d, cnt_q;
  logic                         ready_d, ready_q;
  logic                         flush_d, flush_q;
  logic signed [WIDTH_FULL-1:0] mix_d, mix_q;
  logic                         mix_valid_d, mix_valid_q;
  logic                         overrun_d, overrun_q;
  logic signed [WIDTH_FULL-1:0] acc;
  logic                         accept, last_beat, frame_start;

  assign accept      = bus.voice_valid_in && ready_q;
  assign last_beat   = accept && (cnt_q == LastBeat);
  assign frame_start = bus.sample_tick_in && (state_q == StIdle);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flush_d     = flush_q;
    mix_d       = mix_q;
    mix_valid_d = 1'b0;
    ready_d     = 1'b0;
    overrun_d   = bus.sample_tick_in && (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (bus.sample_tick_in) begin
          cnt_d   = '0;
          state_d = StCollect;
        end
      end
      StCollect: begin
        // Ready is registered: it rises one cycle into COLLECT and falls right after the last beat.
        ready_d = !last_beat;
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (last_beat) begin
          flush_d = 1'b0;
          state_d = StFlush;
        end
      end
      StFlush: begin
        // Two cycles lets the final product pass both MAC stages.
        flush_d = 1'b1;
        if (flush_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        mix_d       = acc;
        mix_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      flush_q     <= 1'b0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      flush_q     <= flush_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  voice_mac #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .GAIN_WIDTH  (GAIN_WIDTH),
    .WIDTH_FULL  (WIDTH_FULL)
  ) u_mac (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clear_in (frame_start),
    .en_in    (accept),
    .sample_in(bus.voice_sample_in),
    .gain_in  (bus.voice_gain_in),
    .acc_out  (acc)
  );

  assign bus.voice_ready_out = ready_q;
  assign bus.mix_out         = mix_q;
  assign bus.mix_valid_out   = mix_valid_q;
  assign bus.overrun_out     = overrun_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Randomized self-checking bench for voice_mixer against a sum-of-products frame model.
module tb_voice_mixer;
  localparam int NV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  voice_mixer_if #(
    .NUM_VOICES  (NV),
    .SAMPLE_WIDTH(16),
    .GAIN_WIDTH  (8),
    .WIDTH_FULL  (26)
  ) bus ();

  voice_mixer #(
    .NUM_VOICES  (NV),
    .SAMPLE_WIDTH(16),
    .GAIN_WIDTH  (8),
    .WIDTH_FULL  (26)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int bs[NV];
  int bg[NV];
  int bgap[NV];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic set_all(input int s, input int g, input int gap);
    for (int i = 0; i < NV; i++) begin
      bs[i] = s; bg[i] = g; bgap[i] = gap;
    end
  endtask

  // Caller sits at a negedge. Idle cycles, then a tick, then beats per bs/bg/bgap.
  // Expected timing: ready from 2nd cycle after tick edge; mix_valid 3 edges after the last beat.
  task automatic run_frame(input string tag, input int n_idle, input bit pre_valid, input bit ovr);
    int     consumed = 0;
    int     gap_left;
    int     exp_c = -1;
    int     rdy_err = 0, mv_err = 0, ov_err = 0;
    longint sum = 0;
    bit     exp_ready;
    for (int i = 0; i < n_idle; i++) begin
      @(negedge clk);
      if (bus.voice_ready_out !== 1'b0) rdy_err++;
      if (bus.mix_valid_out !== 1'b0) mv_err++;
      if (bus.overrun_out !== 1'b0) ov_err++;
      bus.sample_tick_in  = 1'b0;
      bus.voice_valid_in  = pre_valid;
      bus.voice_sample_in = 16'($urandom);
      bus.voice_gain_in   = 8'($urandom);
    end
    bus.sample_tick_in = 1'b1;
    gap_left = bgap[0];
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      bus.sample_tick_in = ovr && (c == 2);
      exp_ready = (c >= 1) && (consumed < NV);
      if (bus.voice_ready_out !== exp_ready) rdy_err++;
      if (bus.mix_valid_out !== (c == exp_c)) mv_err++;
      if (bus.overrun_out !== (ovr && c == 3)) ov_err++;
      if (c == exp_c) begin
        chk({tag, ".mix"}, longint'(bus.mix_out), sum);
        break;
      end
      if (consumed < NV) begin
        if (gap_left > 0) begin
          bus.voice_valid_in  = 1'b0;
          bus.voice_sample_in = 16'($urandom);
          bus.voice_gain_in   = 8'($urandom);
          gap_left--;
        end else begin
          bus.voice_valid_in  = 1'b1;
          bus.voice_sample_in = 16'(bs[consumed]);
          bus.voice_gain_in   = 8'(bg[consumed]);
          if (exp_ready) begin
            sum += longint'(bs[consumed]) * longint'(bg[consumed]);
            consumed++;
            if (consumed == NV) exp_c = c + 4;
            else gap_left = bgap[consumed];
          end
        end
      end else begin
        bus.voice_valid_in = 1'b0;
      end
    end
    chk({tag, ".ready_errs"}, rdy_err, 0);
    chk({tag, ".mix_valid_errs"}, mv_err, 0);
    chk({tag, ".overrun_errs"}, ov_err, 0);
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    bus.sample_tick_in  = 1'b0;
    bus.voice_valid_in  = 1'b0;
    bus.voice_sample_in = '0;
    bus.voice_gain_in   = '0;
    repeat (3) @(negedge clk);
    chk("reset.ready", bus.voice_ready_out, 0);
    chk("reset.mix", longint'(bus.mix_out), 0);
    chk("reset.mix_valid", bus.mix_valid_out, 0);
    chk("reset.overrun", bus.overrun_out, 0);
    rst = 1'b0;

    set_all(1000, 128, 0);
    run_frame("basic", 2, 1'b0, 1'b0);
    set_all(-32768, 255, 0);
    run_frame("neg_extreme", 0, 1'b0, 1'b0);
    set_all(32767, 255, 0);
    run_frame("pos_extreme", 1, 1'b0, 1'b0);
    bs = '{30000, -30000, -5, 7};
    bg = '{255, 255, 1, 2};
    bgap = '{0, 3, 3, 3};
    run_frame("mixed_gaps", 2, 1'b0, 1'b0);
    set_all(1000, 128, 0);
    bs[0] = -1234;
    run_frame("pre_valid", 5, 1'b1, 1'b0);
    set_all(1000, 128, 0);
    run_frame("overrun", 1, 1'b0, 1'b1);

    // Abort a frame after two beats with a reset.
    @(negedge clk);
    bus.sample_tick_in = 1'b1;
    @(negedge clk);
    bus.sample_tick_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.voice_valid_in  = 1'b1;
      bus.voice_sample_in = 16'(500);
      bus.voice_gain_in   = 8'(9);
    end
    @(negedge clk);
    bus.voice_valid_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset.ready", bus.voice_ready_out, 0);
    chk("midreset.mix", longint'(bus.mix_out), 0);
    chk("midreset.mix_valid", bus.mix_valid_out, 0);
    chk("midreset.overrun", bus.overrun_out, 0);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.mix_valid_out !== 1'b0 || bus.voice_ready_out !== 1'b0) bad++;
    end
    chk("midreset.quiet", bad, 0);
    set_all(100, 4, 0);
    run_frame("after_reset", 0, 1'b0, 1'b0);

    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < NV; i++) begin
        bs[i]   = int'($urandom_range(0, 65535)) - 32768;
        bg[i]   = int'($urandom_range(0, 255));
        bgap[i] = int'($urandom_range(0, 3));
      end
      run_frame($sformatf("rand%0d", f), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
